// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel tick timer.
package multi_timer_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Prescaler divisors for a 50 MHz clock.
  localparam int unsigned TICK_DIV_1S  = 50_000_000;
  localparam int unsigned TICK_DIV_1US = 50;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM with a tick-driven down-counter.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             busy_o,
  output logic             expire_o,
  output logic [CNT_W-1:0] count_o
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] load_q;
  logic             periodic_q;
  logic             expire_q;

  // Channel FSM; priority stop > start > tick, all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      load_q     <= '0;
      periodic_q <= MODE_ONESHOT;
      expire_q   <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (stop_i) begin
        state_q <= ST_IDLE;
        count_q <= '0;
      end else if (start_i) begin
        // A zero load never starts a channel and stops a running one.
        if (load_i != '0) begin
          state_q    <= ST_RUN;
          count_q    <= load_i;
          load_q     <= load_i;
          periodic_q <= periodic_i;
        end else begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      end else if (state_q == ST_RUN && tick_i) begin
        if (count_q == CNT_W'(1)) begin
          expire_q <= 1'b1;
          if (periodic_q == MODE_PERIODIC) begin
            count_q <= load_q;
          end else begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        end else begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  assign busy_o   = (state_q == ST_RUN);
  assign expire_o = expire_q;
  assign count_o  = count_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel tick timer: shared prescaler plus NUM_CH independent channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_1S,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    clk_50m,
  input  logic                    reset_n,
  input  logic                    tick_clr,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH*CNT_W-1:0] ch_load,
  output logic                    tick_o,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_expire,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;

  // Prescaler next state: wrap at TICK_DIV-1, tick_clr restarts the phase.
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_d = 1'b0;
    if (tick_clr) begin
      pre_d = '0;
    end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Prescaler and registered tick.
  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i     (clk_50m),
      .rst_ni    (reset_n),
      .tick_i    (tick_q),
      .start_i   (ch_start[g]),
      .stop_i    (ch_stop[g]),
      .periodic_i(ch_periodic[g]),
      .load_i    (ch_load[g*CNT_W +: CNT_W]),
      .busy_o    (ch_busy[g]),
      .expire_o  (ch_expire[g]),
      .count_o   (ch_count[g*CNT_W +: CNT_W])
    );
  end

endmodule
